// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Definitions shared by the instruction-fetch stage and its IF/ID register:
// the data width, the canonical NOP used for pipeline bubbles, and the IF/ID
// pipeline-register payload struct with its bubble value.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // Value held by IF/ID after reset or a flush.
    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Loads a new fetch packet each cycle unless stalled;
// a flush overrides a stall and inserts a bubble. Reset also leaves a bubble.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   stall  in   hold current contents
//   flush  in   replace contents with a bubble (beats stall)
//   d      in   packet from fetch
//   q      out  packet presented to decode
// -----------------------------------------------------------------------------
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the PC, drives
// the instruction-memory address, picks the next PC (EX redirect, stall hold or
// sequential +4) and registers the fetched word into IF/ID.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_cnt / redirect_cnt
// performance counters and their ports.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   stall_f         hold PC
//   stall_d         hold IF/ID
//   flush_d         bubble into IF/ID
//   pc_src_e        taken branch/jump redirect from EX
//   pc_target_e     redirect target (bits [1:0] ignored)
//   imem_addr       instruction-memory address (= PC)
//   imem_rdata      instruction word, combinational from imem_addr
//   instr_d, pc_d, pc_plus4_d, valid_d   IF/ID contents for decode
//   fetch_cnt, redirect_cnt              counters (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] fetch_cnt,
    output logic [XLEN-1:0] redirect_cnt
`endif
);

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_next;
    logic            flush_eff;
    if_id_t          if_id_in;
    if_id_t          if_id_out;

    // Target low bits are discarded: fetch is always word aligned.
    logic            unused_target_lsbs;
    assign unused_target_lsbs = ^pc_target_e[1:0];

    assign imem_addr  = pc_f;
    assign pc_plus4_f = pc_f + XLEN'(4);

    // A redirect wins over a stall so a taken branch is never dropped by a
    // simultaneous load-use hold.
    always_comb begin
        pc_next = pc_plus4_f;
        if (pc_src_e) begin
            pc_next = {pc_target_e[XLEN-1:2], 2'b00};
        end else if (stall_f) begin
            pc_next = pc_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f <= RESET_PC;
        end else begin
            pc_f <= pc_next;
        end
    end

    // The word in decode belongs to the wrong path whenever EX redirects.
    assign flush_eff = flush_d | pc_src_e;

    always_comb begin
        if_id_in          = IF_ID_BUBBLE;
        if_id_in.instr    = imem_rdata;
        if_id_in.pc       = pc_f;
        if_id_in.pc_plus4 = pc_plus4_f;
        if_id_in.valid    = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall_d),
        .flush (flush_eff),
        .d     (if_id_in),
        .q     (if_id_out)
    );

    assign instr_d    = if_id_out.instr;
    assign pc_d       = if_id_out.pc;
    assign pc_plus4_d = if_id_out.pc_plus4;
    assign valid_d    = if_id_out.valid;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            // Count only edges where IF/ID loads a real instruction.
            if (!flush_eff && !stall_d) begin
                fetch_cnt <= fetch_cnt + XLEN'(1);
            end
            if (pc_src_e) begin
                redirect_cnt <= redirect_cnt + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed testbench for fetch_stage with RESET_PC = 0x100. The instruction
// memory returns 32'h00500093 at 0x100 and {16'hABCD, addr[15:0]} elsewhere.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr == 32'h0000_0100) ? 32'h0050_0093
                                                     : {16'hABCD, imem_addr[15:0]};

    fetch_stage #(
        .RESET_PC (32'h0000_0100),
        .XLEN     (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_src_e     (pc_src_e),
        .pc_target_e  (pc_target_e),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset state
        #12;
        chk("rst_imem_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_instr", instr_d, 32'h13);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_pc_plus4", pc_plus4_d, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("rst_redirect_cnt", redirect_cnt, 32'h0);
`endif
        rst_n = 1'b1;

        // First edge: word at RESET_PC enters decode
        step();
        chk("e1_instr", instr_d, 32'h0050_0093);
        chk("e1_pc_d", pc_d, 32'h100);
        chk("e1_pc_plus4", pc_plus4_d, 32'h104);
        chk("e1_valid", {31'b0, valid_d}, 32'h1);
        chk("e1_imem_addr", imem_addr, 32'h104);

        step();
        chk("e2_pc_d", pc_d, 32'h104);
        chk("e2_instr", instr_d, 32'hABCD_0104);
        chk("e2_imem_addr", imem_addr, 32'h108);

        // Stall both stages for two cycles with PC at 0x108
        stall_f = 1'b1;
        stall_d = 1'b1;
        step();
        chk("st1_imem_addr", imem_addr, 32'h108);
        chk("st1_instr", instr_d, 32'hABCD_0104);
        step();
        chk("st2_imem_addr", imem_addr, 32'h108);
        chk("st2_pc_d", pc_d, 32'h104);
        chk("st2_valid", {31'b0, valid_d}, 32'h1);
        idle();

        step();
        chk("res_pc_d", pc_d, 32'h108);
        chk("res_instr", instr_d, 32'hABCD_0108);
        chk("res_imem_addr", imem_addr, 32'h10C);
        step();
        chk("seq4_pc_d", pc_d, 32'h10C);
        chk("seq4_valid", {31'b0, valid_d}, 32'h1);
        chk("seq4_imem_addr", imem_addr, 32'h110);

        // Redirect to misaligned target while stall_f is high
        pc_src_e    = 1'b1;
        pc_target_e = 32'h203;
        stall_f     = 1'b1;
        step();
        chk("rd_imem_addr", imem_addr, 32'h200);
        chk("rd_valid", {31'b0, valid_d}, 32'h0);
        chk("rd_instr", instr_d, 32'h13);
        chk("rd_pc_d", pc_d, 32'h0);
        idle();
        step();
        chk("rd2_pc_d", pc_d, 32'h200);
        chk("rd2_instr", instr_d, 32'hABCD_0200);
        chk("rd2_valid", {31'b0, valid_d}, 32'h1);
        chk("rd2_imem_addr", imem_addr, 32'h204);

        // Flush together with stall_d: bubble, PC keeps advancing
        flush_d = 1'b1;
        stall_d = 1'b1;
        step();
        chk("fl_instr", instr_d, 32'h13);
        chk("fl_valid", {31'b0, valid_d}, 32'h0);
        chk("fl_imem_addr", imem_addr, 32'h208);
        // Same with stall_f: PC held
        stall_f = 1'b1;
        step();
        chk("fls_imem_addr", imem_addr, 32'h208);
        chk("fls_valid", {31'b0, valid_d}, 32'h0);
        idle();
        step();
        chk("fl_res_pc_d", pc_d, 32'h208);
        chk("fl_res_instr", instr_d, 32'hABCD_0208);

        // Wrap of PC at top of address space
        pc_src_e    = 1'b1;
        pc_target_e = 32'hFFFF_FFFF;
        step();
        chk("wr_imem_addr", imem_addr, 32'hFFFF_FFFC);
        idle();
        step();
        chk("wr_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wr_pc_plus4", pc_plus4_d, 32'h0);
        chk("wr_imem_next", imem_addr, 32'h0);
        chk("wr_instr", instr_d, 32'hABCD_FFFC);

        // Asynchronous reset mid-run, away from any clock edge
        rst_n = 1'b0;
        #1;
        chk("ar_imem_addr", imem_addr, 32'h100);
        chk("ar_valid", {31'b0, valid_d}, 32'h0);
        chk("ar_instr", instr_d, 32'h13);
        chk("ar_pc_d", pc_d, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("ar_fetch_cnt", fetch_cnt, 32'h0);
        chk("ar_redirect_cnt", redirect_cnt, 32'h0);
`endif
        rst_n = 1'b1;

        // Ten edges, the fifth carrying a redirect to 0x300
        for (int i = 0; i < 10; i++) begin
            pc_src_e    = (i == 4);
            pc_target_e = (i == 4) ? 32'h300 : 32'h0;
            step();
        end
        idle();
        chk("run_pc_d", pc_d, 32'h310);
        chk("run_imem_addr", imem_addr, 32'h314);
        chk("run_valid", {31'b0, valid_d}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
        chk("run_fetch_cnt", fetch_cnt, 32'd9);
        chk("run_redirect_cnt", redirect_cnt, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("run_rst_fetch_cnt", fetch_cnt, 32'h0);
        chk("run_rst_redirect_cnt", redirect_cnt, 32'h0);
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: holds the PC, drives the instruction-memory address, selects the next PC (sequential or an EX-stage branch/jump redirect), and registers the fetched word into the IF/ID pipeline register. Its `instr_d` output feeds the decode stage, where `instr_d[31:7]` drives the immediate extender. It also consumes the extender's result indirectly, via the EX-stage target `pc_target_e = pc_e + imm_ext`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset (word aligned).
- `XLEN`, 32, data/address width; only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_f`  in  1  hold PC (from hazard unit).
- `stall_d`  in  1  hold IF/ID register.
- `flush_d`  in  1  replace IF/ID contents with a bubble.
- `pc_src_e`  in  1  taken branch/jump redirect from EX.
- `pc_target_e`  in  32  redirect target from EX.
- `imem_addr`  out  32  instruction-memory address; equals `pc_f`.
- `imem_rdata`  in  32  instruction word; combinational from `imem_addr`.
- `instr_d`  out  32  instruction in decode.
- `pc_d`  out  32  PC of `instr_d`.
- `pc_plus4_d`  out  32  `pc_d + 4`.
- `valid_d`  out  1  `instr_d` is a real instruction, not a bubble.
- `fetch_cnt`, `redirect_cnt`  out  32 each  present only with `FETCH_PERF_CNT_EN`.

## Operation
- The internal `pc_f` drives `imem_addr` directly.
- Next-PC selection, highest priority first:
  - `pc_src_e` → `{pc_target_e[31:2],2'b00}`. Bits [1:0] of the target are ignored.
  - `stall_f` → hold.
  - otherwise → `pc_f + 4`, wrapping modulo 2^32.
- Redirect beats stall: a taken branch is never lost to a simultaneous load-use stall.
- IF/ID update: the effective flush is `flush_d | pc_src_e`. Priority, highest first:
  - effective flush → `instr_d = NOP_INSTR` (32'h0000_0013), `pc_d = 0`, `pc_plus4_d = 0`, `valid_d = 0`.
  - `stall_d` → hold all IF/ID fields.
  - otherwise → `instr_d = imem_rdata`, `pc_d = pc_f`, `pc_plus4_d = pc_f + 4`, `valid_d = 1`.
- Flush beats stall: `flush_d` and `stall_d` together produce a bubble.
- The block performs no decoding; illegal opcodes pass through unchanged.

## Timing
- Reset values (asserted asynchronously, released synchronously by the surrounding reset logic):
  - `pc_f` = `imem_addr` = `RESET_PC`
  - `instr_d` = `NOP_INSTR`
  - `pc_d` = `pc_plus4_d` = 0
  - `valid_d` = 0
  - counters = 0
- First clock edge after reset release: the word at `RESET_PC` enters decode with `valid_d = 1`.
- Fetch latency: a PC appears on `imem_addr` in cycle N; its instruction appears on `instr_d` in cycle N+1.
- Redirect asserted in cycle N:
  - `pc_f` = target in N+1.
  - Decode holds a bubble in N+1.
  - The target instruction appears on `instr_d` in N+2.
- Branch penalty is two slots. The instruction in decode is squashed here; squashing the instruction in EX is the hazard unit's job via `flush_e`.
- Reset asserted mid-operation: all state returns to reset values immediately; no in-flight instruction survives.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined:
  - `fetch_cnt` increments on every edge where IF/ID loads a real instruction (the otherwise branch of the IF/ID update).
  - `redirect_cnt` increments on every edge with `pc_src_e = 1`.
  - Both are 32-bit, wrap at 2^32, are reset to 0, and are exposed as ports.
- Not defined: counters and their ports are absent; the functional behaviour is identical.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`
  - `NOP_INSTR`
  - an `if_id_t` struct with fields `instr`, `pc`, `pc_plus4`, `valid`
- One sub-module `if_id_reg` implements the IF/ID register (stall/flush priority and reset bubble), taking an `if_id_t`.
- The PC register, next-PC mux and counters live in `fetch_stage`.

## Test plan
- Reset with `RESET_PC = 32'h100` and memory word 32'h00500093 at 0x100:
  - during reset: `imem_addr` = 0x100, `valid_d` = 0, `instr_d` = 32'h13
  - first edge: `instr_d` = 32'h00500093, `pc_d` = 0x100, `pc_plus4_d` = 0x104
- Straight-line fetch of 4 cycles: `pc_d` steps 0x100, 0x104, 0x108, 0x10C with `valid_d` held at 1.
- `stall_f` = `stall_d` = 1 for 2 cycles at PC 0x108: `imem_addr` and `instr_d` both frozen; on release, fetch resumes at 0x108 with no instruction lost or repeated.
- `pc_src_e` = 1 with `pc_target_e` = 32'h203 while `stall_f` = 1:
  - next cycle: `imem_addr` = 0x200, `valid_d` = 0
  - cycle after: `pc_d` = 0x200
- `flush_d` = `stall_d` = 1 together: bubble (`instr_d` = 32'h13, `valid_d` = 0); the PC still advances unless `stall_f` is set.
- With `FETCH_PERF_CNT_EN`: 10 fetches containing one redirect give `fetch_cnt` = 9 and `redirect_cnt` = 1. `rst_n` low mid-run clears both counters to 0 asynchronously.
